// File: rtl/timer_dev.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) whose irq output drives a CP0 HWInt bit.
// Optional prescaler in CTRL[15:8] is built when TIMER_PRESCALE_EN is defined.
module timer_dev #(
    parameter int COUNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t               state, state_nxt;
    logic                 en, im;
    logic [1:0]           mode;
    logic [COUNT_W-1:0]   preset, count, count_nxt;
    logic                 irq_flag;
    logic                 ctrl_we, preset_we;
    logic                 en_auto_clr, flag_set, flag_clr;
    logic                 step;

`ifdef TIMER_PRESCALE_EN
    logic [7:0] psc_val, psc_cnt, psc_cnt_nxt;
    assign step = (psc_cnt == psc_val);
`else
    assign step = 1'b1;
`endif

    assign ctrl_we   = we && (addr == 2'd0);
    assign preset_we = we && (addr == 2'd1);
    assign irq       = irq_flag & im;

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        en_auto_clr = 1'b0;
        flag_set    = 1'b0;
        flag_clr    = 1'b0;
`ifdef TIMER_PRESCALE_EN
        psc_cnt_nxt = psc_cnt;
`endif
        case (state)
            IDLE: if (en) state_nxt = LOAD;
            LOAD: begin
                count_nxt = preset;
                state_nxt = CNT;
`ifdef TIMER_PRESCALE_EN
                psc_cnt_nxt = 8'd0;
`endif
            end
            CNT: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else begin
`ifdef TIMER_PRESCALE_EN
                    psc_cnt_nxt = step ? 8'd0 : psc_cnt + 8'd1;
`endif
                    if (step) begin
                        // A preset of 0 or 1 terminates on the first step.
                        if (count > COUNT_W'(1)) begin
                            count_nxt = count - COUNT_W'(1);
                        end else begin
                            count_nxt = '0;
                            flag_set  = 1'b1;
                            state_nxt = INT;
                        end
                    end
                end
            end
            INT: begin
                if (mode == 2'd1) begin
                    flag_clr  = 1'b1;
                    state_nxt = LOAD;
                end else begin
                    en_auto_clr = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            preset   <= '0;
            en       <= 1'b0;
            mode     <= 2'd0;
            im       <= 1'b0;
            irq_flag <= 1'b0;
`ifdef TIMER_PRESCALE_EN
            psc_val  <= 8'd0;
            psc_cnt  <= 8'd0;
`endif
        end else begin
            state <= state_nxt;
            count <= count_nxt;
`ifdef TIMER_PRESCALE_EN
            psc_cnt <= psc_cnt_nxt;
`endif
            // Bus writes take priority over the FSM's own EN clear and flag set.
            if (ctrl_we) begin
                en   <= din[0];
                mode <= din[2:1];
                im   <= din[3];
`ifdef TIMER_PRESCALE_EN
                psc_val <= din[15:8];
`endif
            end else if (en_auto_clr) begin
                en <= 1'b0;
            end
            if (preset_we) preset <= din[COUNT_W-1:0];
            if (ctrl_we || preset_we) irq_flag <= 1'b0;
            else if (flag_set)        irq_flag <= 1'b1;
            else if (flag_clr)        irq_flag <= 1'b0;
        end
    end

    always_comb begin
        dout = 32'd0;
        case (addr)
`ifdef TIMER_PRESCALE_EN
            2'd0: dout = {16'd0, psc_val, 4'd0, im, mode, en};
`else
            2'd0: dout = {28'd0, im, mode, en};
`endif
            2'd1: dout = 32'(preset);
            2'd2: dout = 32'(count);
            default: dout = 32'd0;
        endcase
    end

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped countdown timer on the CPU's peripheral bus (bridge side).
- Initiator end of the hardware-interrupt path: its irq output drives one HWInt bit of the coprocessor-0 interrupt logic.
- Two modes: one-shot with a held interrupt (mode 0) and auto-reload with a periodic one-cycle pulse (mode 1).
- Registers are CTRL, PRESET and COUNT; COUNT is read-only.

Parameters:
- COUNT_W, 32, width of PRESET and COUNT. Bus data stays 32 bits; upper bits are zero-extended on read and dropped on write.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- addr  input  2  word offset: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
- we  input  1  bus write strobe; sampled on posedge clk.
- din  input  32  bus write data.
- dout  output  32  bus read data; combinational from addr.
- irq  output  1  interrupt request to CP0 HWInt.

Behaviour:
- CTRL bits: [0] EN; [2:1] MODE; [3] IM (interrupt mask); other bits read 0. MODE 2/3 behave as mode 0.
- Reset: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, therefore irq=0 and dout reflects zeros.
- Reads: addr0={28'b0,CTRL[3:0]}; addr1=PRESET; addr2=COUNT; addr3=0.
- Writes:
  - addr0 loads CTRL[3:0].
  - addr1 loads PRESET.
  - addr2 and addr3 are ignored.
  - Any write to addr0 or addr1 clears irq_flag on the same edge.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: EN=1 -> LOAD.
  - LOAD: COUNT<=PRESET -> CNT.
  - CNT, EN=0: -> IDLE, COUNT frozen.
  - CNT, EN=1 and COUNT>1: COUNT<=COUNT-1.
  - CNT, EN=1 and COUNT<=1: COUNT<=0, irq_flag<=1 -> INT.
  - INT, mode 0: EN<=0 -> IDLE; irq_flag holds until a CTRL/PRESET write or reset.
  - INT, mode 1: irq_flag<=0 -> LOAD.
- irq = irq_flag & IM. Clearing IM masks the output but does not clear irq_flag.
- Latency:
  - CTRL write with EN=1 at edge E0 gives LOAD at E1, CNT with COUNT=PRESET at E2, INT/irq at E0+2+max(PRESET,1).
  - Mode-1 period is PRESET+2 cycles, with irq high exactly 1 cycle.
- Simultaneous events:
  - A bus CTRL write on the same edge as the INT mode-0 EN auto-clear: the bus value wins.
  - The bus flag-clear beats the flag-set on the same edge.
- PRESET written during CNT does not alter COUNT; it takes effect at the next LOAD.
- EN=0 written while in INT: mode 0 -> IDLE as normal; mode 1 -> LOAD, which then proceeds to CNT and from there to IDLE on the next cycle.
- Reset mid-count returns all state to reset values on that edge.

Optional Feature:
- Macro TIMER_PRESCALE_EN.
- Defined:
  - CTRL[15:8] is a writable, readable prescale value P.
  - An internal 8-bit prescale counter is cleared in LOAD.
  - In CNT the COUNT update and termination check happen only when the prescale counter equals P; that step also resets the prescale counter. Otherwise the prescale counter increments.
  - Each COUNT step therefore takes P+1 cycles.
- Undefined: CTRL[15:8] reads 0 and writes are ignored; COUNT steps every cycle.

Test Plan:
- Reset, then read addr0/1/2 -> all 0 and irq=0.
- PRESET=5, CTRL=0x9 (EN, mode0, IM) at E0 -> irq rises after E0+7, EN reads 0, COUNT=0; irq stays high until a CTRL write of 0x8 clears it on that edge.
- PRESET=3, CTRL=0xB (mode1, IM) -> irq pulses for 1 cycle every 5 cycles; COUNT sequence 3,2,1,0 repeats.
- Mode1 running, CTRL=0x2 (EN=0) written mid-CNT -> state IDLE next cycle, COUNT frozen at its current value, no further irq.
- Mode0 with IM=0 and PRESET=2 -> irq_flag sets, irq stays 0; later CTRL=0x8 write clears the flag so irq stays 0. PRESET=0 test: INT occurs 3 edges after the enable write.
- (TIMER_PRESCALE_EN) CTRL=0x0309, PRESET=2 -> COUNT steps every 4 cycles; irq after E0+2+8 edges.
